// File: rtl/lifo_arb_pkg.sv
// Shared types for the LIFO arbiter: FSM state encoding and client opcodes.
// Latency: none, declarations only.
// Backpressure: not applicable.
package lifo_arb_pkg;

    // Arbiter sequencing: IDLE arbitrates, PUSH/POP drive the LIFO strobe,
    // POP_CAP captures the read data the LIFO returns one cycle after a pop.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PUSH    = 2'd1,
        POP     = 2'd2,
        POP_CAP = 2'd3
    } state_t;

    // Per-client opcode carried on op_i.
    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

endpackage

// File: rtl/lifo_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after last_winner+1, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_winner,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IW-1:0]      idx,
    output logic               any
);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    // Walk offsets 1..NUM_REQ from the last winner; the last winner itself is
    // visited last so a lone requester can still win back-to-back.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        sum    = '0;
        cand   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            sum = {1'b0, last_winner} + (IW+1)'(i);
            if (sum >= (IW+1)'(NUM_REQ)) begin
                sum = sum - (IW+1)'(NUM_REQ);
            end
            cand = sum[IW-1:0];
            if (!any && req[cand]) begin
                any          = 1'b1;
                onehot[cand] = 1'b1;
                idx          = cand;
            end
        end
    end

endmodule

// File: rtl/lifo_arbiter.sv
// Arbitrates NUM_REQ clients onto one shared LIFO, one push or pop at a time.
// Latency: grant/strobe one cycle after the request is seen in IDLE; pop data valid three cycles after.
// Backpressure: requests that would overflow/underflow the LIFO are held until the flag clears.
module lifo_arbiter
    import lifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DWIDTH  = 8
) (
    input  logic                      clk_i,
    input  logic                      arst_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        op_i,
    input  logic [NUM_REQ*DWIDTH-1:0] data_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        rvalid_o,
    output logic [DWIDTH-1:0]         rdata_o,
    output logic                      lifo_wrreq_o,
    output logic                      lifo_rdreq_o,
    output logic [DWIDTH-1:0]         lifo_data_o,
    input  logic                      lifo_empty_i,
    input  logic                      lifo_full_i,
    input  logic [DWIDTH-1:0]         lifo_q_i,
    output logic                      busy_o
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t               state;
    logic [IW-1:0]        last_winner;
    logic [NUM_REQ-1:0]   win_oh;
    logic [NUM_REQ-1:0]   elig;
    logic [NUM_REQ-1:0]   pick_oh;
    logic [IW-1:0]        pick_idx;
    logic                 pick_any;
    logic                 pick_op;
    logic [DWIDTH-1:0]    pick_data;

    // A request only competes if the LIFO can actually serve its opcode now.
    always_comb begin
        elig = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            elig[k] = req_i[k] &
                      (((op_i[k] == OP_PUSH) && !lifo_full_i) ||
                       ((op_i[k] == OP_POP)  && !lifo_empty_i));
        end
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_picker (
        .req         (elig),
        .last_winner (last_winner),
        .onehot      (pick_oh),
        .idx         (pick_idx),
        .any         (pick_any)
    );

    assign pick_op   = op_i[pick_idx];
    assign pick_data = data_i[pick_idx*DWIDTH +: DWIDTH];

    // busy follows the state register directly, so it is glitch-free.
    assign busy_o = (state != IDLE);

    // Sequencer: all strobes and pulses are registered one cycle ahead of the
    // state they belong to, so they coincide with PUSH/POP/the cycle after POP_CAP.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state        <= IDLE;
            last_winner  <= IW'(NUM_REQ - 1);
            win_oh       <= '0;
            gnt_o        <= '0;
            rvalid_o     <= '0;
            rdata_o      <= '0;
            lifo_wrreq_o <= 1'b0;
            lifo_rdreq_o <= 1'b0;
            lifo_data_o  <= '0;
        end else begin
            gnt_o        <= '0;
            rvalid_o     <= '0;
            lifo_wrreq_o <= 1'b0;
            lifo_rdreq_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        win_oh      <= pick_oh;
                        last_winner <= pick_idx;
                        gnt_o       <= pick_oh;
                        if (pick_op == OP_PUSH) begin
                            lifo_wrreq_o <= 1'b1;
                            lifo_data_o  <= pick_data;
                            state        <= PUSH;
                        end else begin
                            lifo_rdreq_o <= 1'b1;
                            state        <= POP;
                        end
                    end
                end
                PUSH: begin
                    state <= IDLE;
                end
                POP: begin
                    // LIFO read data arrives during POP_CAP.
                    state <= POP_CAP;
                end
                POP_CAP: begin
                    rdata_o  <= lifo_q_i;
                    rvalid_o <= win_oh;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
